// File: rtl/registro_piso_tx.sv
// Parallel-in/serial-out transmitter: loads a word, shifts it out MSB-first one bit per i_tick, then pulses o_done.
// Latency: MSB on o_serial the cycle after the load edge; o_done W cycles later with i_tick held high; ready again one cycle after.
// Backpressure: i_load is taken only while o_ready=1; loads while busy are dropped. i_tick paces the bits.
module registro_piso_tx #(
  parameter int REGISTER_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic [REGISTER_WIDTH-1:0] i_data,
  input  logic                      i_tick,
  output logic                      o_ready,
  output logic                      o_serial,
  output logic                      o_bit_valid,
  output logic                      o_done
);

  localparam int CW = $clog2(REGISTER_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [REGISTER_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]           count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_load) state_d = SHIFT;
      SHIFT:   if (i_tick && (count_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter stops at zero: the final tick moves to DONE instead of decrementing.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (state_q == IDLE && i_load) begin
      shreg_d = i_data;
      count_d = CW'(REGISTER_WIDTH - 1);
    end else if (state_q == SHIFT && i_tick && (count_q != '0)) begin
      shreg_d = {shreg_q[REGISTER_WIDTH-2:0], 1'b0};
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    o_ready     = (state_q == IDLE);
    o_bit_valid = (state_q == SHIFT);
    o_serial    = (state_q == SHIFT) ? shreg_q[REGISTER_WIDTH-1] : 1'b0;
    o_done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_registro_piso_tx.sv
// Bench for registro_piso_tx: directed scenarios plus random traffic against a frame/bit-index reference model.
module tb_registro_piso_tx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_load, i_tick;
  logic [W-1:0] i_data;
  logic         o_ready, o_serial, o_bit_valid, o_done;

  logic         l4, t4;
  logic [3:0]   d4;
  logic         r4, s4, v4, dn4;

  int passed = 0;
  int total  = 0;

  // Reference model: 0 idle, 1 sending bit m_idx of m_word, 2 done
  int           m_mode;
  int           m_idx;
  logic [W-1:0] m_word;

  registro_piso_tx #(.REGISTER_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_data(i_data), .i_tick(i_tick),
    .o_ready(o_ready), .o_serial(o_serial), .o_bit_valid(o_bit_valid), .o_done(o_done)
  );

  registro_piso_tx #(.REGISTER_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .i_load(l4), .i_data(d4), .i_tick(t4),
    .o_ready(r4), .o_serial(s4), .o_bit_valid(v4), .o_done(dn4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic es;
    es = (m_mode == 1) ? m_word[W-1-m_idx] : 1'b0;
    chk({tag, ".ready"},  32'(o_ready),     32'(m_mode == 0));
    chk({tag, ".valid"},  32'(o_bit_valid), 32'(m_mode == 1));
    chk({tag, ".serial"}, 32'(o_serial),    32'(es));
    chk({tag, ".done"},   32'(o_done),      32'(m_mode == 2));
  endtask

  task automatic cycle(input string tag, input logic ld, input logic [W-1:0] d, input logic tk);
    i_load = ld;
    i_data = d;
    i_tick = tk;
    @(posedge clk);
    case (m_mode)
      0: if (ld) begin m_word = d; m_idx = 0; m_mode = 1; end
      1: if (tk) begin
           if (m_idx == W - 1) m_mode = 2;
           else m_idx++;
         end
      default: m_mode = 0;
    endcase
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [3:0]   w4;
    int           dones;

    rst = 1'b1; i_load = 1'b0; i_tick = 1'b0; i_data = '0;
    l4 = 1'b0; t4 = 1'b0; d4 = '0;
    m_mode = 0; m_idx = 0; m_word = '0;
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame
    got = '0;
    cycle("basic", 1'b1, 16'hA5C3, 1'b1);
    for (int i = 0; i < 18; i++) begin
      if (o_bit_valid) got = {got[W-2:0], o_serial};
      cycle("basic", 1'b0, W'($urandom), 1'b1);
    end
    chk("basic.word", 32'(got), 32'h0000A5C3);

    // Paced ticks every third cycle
    cycle("paced", 1'b1, 16'h8001, 1'b0);
    for (int i = 0; i < 16 * 3 + 3; i++)
      cycle("paced", 1'b0, W'($urandom), (i % 3) == 2);

    // Loads while busy must be dropped
    cycle("busy", 1'b1, 16'h00FF, 1'b1);
    for (int i = 0; i < 18; i++)
      cycle("busy", (i == 4) || (i == 16), 16'hFFFF, 1'b1);

    // Asynchronous reset mid-frame at bit 5
    cycle("arst", 1'b1, W'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) cycle("arst", 1'b0, W'($urandom), 1'b1);
    chk("arst.bit5_valid", 32'(o_bit_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    m_mode = 0;
    check_all("arst.now");
    @(posedge clk); #1;
    check_all("arst.held");
    #3;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("arst.idle", 1'b0, W'($urandom), 1'b1);
      if (o_done) dones++;
    end
    chk("arst.no_done", 32'(dones), 32'd0);
    got = '0;
    cycle("arst.reload", 1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 18; i++) begin
      if (o_bit_valid) got = {got[W-2:0], o_serial};
      cycle("arst.reload", 1'b0, W'($urandom), 1'b1);
    end
    chk("arst.word", 32'(got), 32'h00001234);

    // Back-to-back with i_load held high
    dones = 0;
    for (int i = 0; i < 38; i++) begin
      cycle("b2b", 1'b1, (i < 18) ? 16'hF00F : 16'h0FF0, 1'b1);
      if (o_done) begin
        dones++;
        chk("b2b.done_at", 32'(i), (dones == 1) ? 32'd16 : 32'd34);
      end
    end
    for (int i = 0; i < 20; i++) cycle("b2b.drain", 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(3) == 0), W'($urandom), $urandom_range(1) == 1);
    for (int i = 0; i < 40; i++) cycle("rand.drain", 1'b0, '0, 1'b1);

    // W=4 instance
    w4 = 4'b1001;
    l4 = 1'b1; d4 = w4; t4 = 1'b1;
    @(posedge clk); #1;
    l4 = 1'b0; d4 = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      chk("w4.serial", 32'(s4), 32'(w4[3-k]));
      chk("w4.valid",  32'(v4), 32'd1);
      chk("w4.done",   32'(dn4), 32'd0);
      @(posedge clk); #1;
    end
    chk("w4.done_pulse", 32'(dn4), 32'd1);
    chk("w4.valid_off",  32'(v4),  32'd0);
    @(posedge clk); #1;
    chk("w4.ready", 32'(r4),  32'd1);
    chk("w4.done_end", 32'(dn4), 32'd0);
    @(posedge clk); #1;
    chk("w4.stay_idle", 32'(v4), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
